// File: rtl/cr_huf_comp_is_lanes.sv
// Multi-lane insertion sorter between the symbol counter and the Huffman tree builder.
// Optional macro CR_HUF_COMP_IS_SYM_TIEBREAK_EN: equal frequencies ordered by ascending symbol.
module cr_huf_comp_is_lanes #(
    parameter int DAT_WIDTH        = 6,
    parameter int CNT_WIDTH        = 20,
    parameter int MAX_NUM_SYM_USED = 64,
    parameter int NUM_LANES        = 4,
    parameter int SEQID_WIDTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_LANES-1:0]                  sc_is_vld,
    input  logic [NUM_LANES*DAT_WIDTH-1:0]        sc_is_sym,
    input  logic [NUM_LANES*CNT_WIDTH-1:0]        sc_is_cnt,
    input  logic [SEQID_WIDTH-1:0]                sc_is_seq_id,
    input  logic                                  sc_is_eob,
    output logic                                  is_sc_rd,
    input  logic                                  ht_is_not_ready,
    output logic                                  is_ht_vld,
    output logic [DAT_WIDTH-1:0]                  is_ht_sym,
    output logic [CNT_WIDTH-1:0]                  is_ht_freq,
    output logic                                  is_ht_eob,
    output logic [SEQID_WIDTH-1:0]                is_ht_seq_id,
    output logic [DAT_WIDTH-1:0]                  is_ht_sym_lo,
    output logic [DAT_WIDTH-1:0]                  is_ht_sym_hi,
    output logic [$clog2(MAX_NUM_SYM_USED+1)-1:0] is_ht_sym_unique,
    output logic                                  is_ht_overflow
);

    localparam int MAX = MAX_NUM_SYM_USED;
    localparam int UW  = $clog2(MAX + 1);
    localparam int IW  = (MAX > 1) ? $clog2(MAX) : 1;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [NUM_LANES-1:0]   done_q, done_d, pend, sel_mask;
    logic                   lane_act, lane_last;
    logic [DAT_WIDTH-1:0]   new_sym;
    logic [CNT_WIDTH-1:0]   new_cnt;

    logic [DAT_WIDTH-1:0]   sym_q   [MAX];
    logic [CNT_WIDTH-1:0]   freq_q  [MAX];
    logic [DAT_WIDTH-1:0]   sym_nx  [MAX];
    logic [CNT_WIDTH-1:0]   freq_nx [MAX];
    logic [MAX-1:0]         ge;
    logic                   full, ins_en, rd_c;
    logic [UW-1:0]          n_q, n_d;
    logic [IW-1:0]          idx_q, idx_d;

    logic                   seen_q, seen_d, ovf_q, ovf_d;
    logic [DAT_WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;

    logic                   vld_q, vld_d, oeob_q, oeob_d, oovf_q, oovf_d;
    logic [DAT_WIDTH-1:0]   osym_q, osym_d, olo_q, olo_d, ohi_q, ohi_d;
    logic [CNT_WIDTH-1:0]   ofreq_q, ofreq_d;
    logic [SEQID_WIDTH-1:0] oseq_q, oseq_d;
    logic [UW-1:0]          ouniq_q, ouniq_d;

    // Lowest pending lane of the head beat is serviced this cycle.
    always_comb begin
        pend     = sc_is_vld & ~done_q;
        lane_act = 1'b0;
        sel_mask = '0;
        new_sym  = '0;
        new_cnt  = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                lane_act    = 1'b1;
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
                new_sym     = sc_is_sym[i*DAT_WIDTH +: DAT_WIDTH];
                new_cnt     = sc_is_cnt[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
        lane_last = lane_act && ((pend & ~sel_mask) == '0);
    end

    assign full = (n_q == UW'(MAX));

    // ge[i]: entry i stays in place ahead of the new entry; always a prefix of the sorted list.
    genvar gi;
    generate
        for (gi = 0; gi < MAX; gi++) begin : g_list
`ifdef CR_HUF_COMP_IS_SYM_TIEBREAK_EN
            assign ge[gi] = (UW'(gi) < n_q) &&
                            ((freq_q[gi] > new_cnt) ||
                             ((freq_q[gi] == new_cnt) && (sym_q[gi] <= new_sym)));
`else
            assign ge[gi] = (UW'(gi) < n_q) && (freq_q[gi] >= new_cnt);
`endif
            if (gi == 0) begin : g_head
                assign sym_nx[gi]  = ge[gi] ? sym_q[gi]  : new_sym;
                assign freq_nx[gi] = ge[gi] ? freq_q[gi] : new_cnt;
            end else begin : g_body
                assign sym_nx[gi]  = ge[gi] ? sym_q[gi]  : (ge[gi-1] ? new_sym : sym_q[gi-1]);
                assign freq_nx[gi] = ge[gi] ? freq_q[gi] : (ge[gi-1] ? new_cnt : freq_q[gi-1]);
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        n_d     = n_q;
        idx_d   = idx_q;
        seen_d  = seen_q;
        ovf_d   = ovf_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        vld_d   = vld_q;
        osym_d  = osym_q;
        ofreq_d = ofreq_q;
        oeob_d  = oeob_q;
        oseq_d  = oseq_q;
        olo_d   = olo_q;
        ohi_d   = ohi_q;
        ouniq_d = ouniq_q;
        oovf_d  = oovf_q;
        rd_c    = 1'b0;
        ins_en  = 1'b0;
        case (state_q)
            ACCUM: begin
                if (lane_act) begin
                    if (new_cnt != '0) begin
                        if (!seen_q) begin
                            lo_d = new_sym;
                            hi_d = new_sym;
                        end else begin
                            if (new_sym < lo_q) lo_d = new_sym;
                            if (new_sym > hi_q) hi_d = new_sym;
                        end
                        seen_d = 1'b1;
                        if (full) begin
                            ovf_d  = 1'b1;
                            ins_en = !ge[MAX-1];
                        end else begin
                            ins_en = 1'b1;
                            n_d    = n_q + 1'b1;
                        end
                    end
                    done_d = lane_last ? '0 : (done_q | sel_mask);
                    rd_c   = lane_last;
                end else if (sc_is_eob) begin
                    rd_c = 1'b1;
                end
                // Block summary is frozen into the output registers as the eob beat pops.
                if (rd_c && sc_is_eob) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    oseq_d  = sc_is_seq_id;
                    olo_d   = lo_d;
                    ohi_d   = hi_d;
                    oovf_d  = ovf_d;
                    ouniq_d = n_d;
                    seen_d  = 1'b0;
                    ovf_d   = 1'b0;
                    lo_d    = '0;
                    hi_d    = '0;
                end
            end
            DRAIN: begin
                if (vld_q && !ht_is_not_ready && oeob_q) begin
                    state_d = ACCUM;
                    n_d     = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    osym_d  = '0;
                    ofreq_d = '0;
                    oeob_d  = 1'b0;
                    oseq_d  = '0;
                    olo_d   = '0;
                    ohi_d   = '0;
                    ouniq_d = '0;
                    oovf_d  = 1'b0;
                end else if (!vld_q || !ht_is_not_ready) begin
                    vld_d = 1'b1;
                    if (n_q == '0) begin
                        osym_d  = '0;
                        ofreq_d = '0;
                        oeob_d  = 1'b1;
                    end else begin
                        osym_d  = sym_q[idx_q];
                        ofreq_d = freq_q[idx_q];
                        oeob_d  = (UW'(idx_q) == n_q - 1'b1);
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // List storage carries no reset: n_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (ins_en) begin
            for (int i = 0; i < MAX; i++) begin
                sym_q[i]  <= sym_nx[i];
                freq_q[i] <= freq_nx[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            done_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            vld_q   <= 1'b0;
            osym_q  <= '0;
            ofreq_q <= '0;
            oeob_q  <= 1'b0;
            oseq_q  <= '0;
            olo_q   <= '0;
            ohi_q   <= '0;
            ouniq_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            vld_q   <= vld_d;
            osym_q  <= osym_d;
            ofreq_q <= ofreq_d;
            oeob_q  <= oeob_d;
            oseq_q  <= oseq_d;
            olo_q   <= olo_d;
            ohi_q   <= ohi_d;
            ouniq_q <= ouniq_d;
            oovf_q  <= oovf_d;
        end
    end

    // Pop strobe is combinational; masked so nothing is acknowledged while held in reset.
    assign is_sc_rd         = rd_c & rst_n;
    assign is_ht_vld        = vld_q;
    assign is_ht_sym        = osym_q;
    assign is_ht_freq       = ofreq_q;
    assign is_ht_eob        = oeob_q;
    assign is_ht_seq_id     = oseq_q;
    assign is_ht_sym_lo     = olo_q;
    assign is_ht_sym_hi     = ohi_q;
    assign is_ht_sym_unique = ouniq_q;
    assign is_ht_overflow   = oovf_q;

endmodule
